// File: rtl/phase_seq_if.sv
// Handshake bundle between requesting agents and phase_seq_arbiter.
// The abort line exists only when SEQ_ABORT_EN is defined.
interface phase_seq_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       req;
  logic [CNT_W-1:0] dwell;
`ifdef SEQ_ABORT_EN
  logic             abort;
`endif
  logic [1:0]       grant;
  logic [1:0]       state;
  logic             busy;
  logic             done;

  modport master (
`ifdef SEQ_ABORT_EN
    output abort,
`endif
    output req, dwell,
    input  grant, state, busy, done
  );

  modport slave (
`ifdef SEQ_ABORT_EN
    input  abort,
`endif
    input  req, dwell,
    output grant, state, busy, done
  );
endinterface

// File: rtl/phase_seq_arbiter.sv
// Round-robin arbiter and dwell timer driving the IDLE->RUN->PH2->PH3 phase code.
// Optional SEQ_ABORT_EN adds an abort input that ends a sequence from RUN or PH2.
module phase_seq_arbiter #(
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  phase_seq_if.slave bus
);

  // The datapath decodes these codes directly, so the encoding is pinned.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PH2  = 2'b10,
    PH3  = 2'b11
  } state_e;

  state_e           state_q, state_nxt;
  logic [1:0]       grant_q, grant_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             prio_q, prio_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             abort_req;

`ifdef SEQ_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // NOTE: every signal gets its default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    cnt_nxt   = cnt_q;
    prio_nxt  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          unique case (bus.req)
            2'b01:   grant_nxt = 2'b01;
            2'b10:   grant_nxt = 2'b10;
            default: grant_nxt = prio_q ? 2'b10 : 2'b01;
          endcase
          state_nxt = RUN;
          cnt_nxt   = (bus.dwell == '0) ? CNT_W'(1) : bus.dwell;
        end
      end
      RUN: begin
        if (abort_req) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          prio_nxt  = grant_q[0];
        end else if (cnt_q == CNT_W'(1)) begin
          state_nxt = PH2;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      PH2: begin
        if (abort_req) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          prio_nxt  = grant_q[0];
        end else begin
          state_nxt = PH3;
        end
      end
      default: begin
        // Serving requester 0 hands the tie-break to requester 1, and vice versa.
        state_nxt = IDLE;
        grant_nxt = 2'b00;
        prio_nxt  = grant_q[0];
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == PH3);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      cnt_q   <= cnt_nxt;
      prio_q  <= prio_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.grant = grant_q;
  assign bus.state = state_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_phase_seq_arbiter.sv
// Self-checking bench for phase_seq_arbiter: per-cycle expected outputs are queued
// when a request is driven and compared as the DUT steps through each phase.
module tb_phase_seq_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phase_seq_if #(.CNT_W(8)) bus ();

  phase_seq_arbiter #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected output tuple: {grant[1:0], state[1:0], busy, done}
  typedef struct {
    logic [5:0] val;
    string      tag;
  } exp_t;

  typedef struct {
    logic [1:0] req;
    logic [7:0] dwell;
    logic [1:0] exp_grant;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: actual g/s/b/d=%b_%b_%b_%b required=%b_%b_%b_%b", name,
               act[5:4], act[3:2], act[1], act[0], req_v[5:4], req_v[3:2], req_v[1], req_v[0]);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [1:0] s, input string tag);
    exp_t e;
    e.val = {g, s, (s != 2'b00), (s == 2'b11)};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [1:0] g, input logic [7:0] d, input string tag);
    int n;
    n = (d == 8'd0) ? 1 : int'(d);
    for (int i = 0; i < n; i++) push(g, 2'b01, {tag, "_run"});
    push(g, 2'b10, {tag, "_ph2"});
    push(g, 2'b11, {tag, "_ph3"});
    push(2'b00, 2'b00, {tag, "_idle"});
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, {bus.grant, bus.state, bus.busy, bus.done}, e.val);
    end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 1000;
    while (exp_q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    if (exp_q.size() > 0) begin
      check({tag, "_timeout"}, 6'(exp_q.size()), 6'd0);
      exp_q.delete();
    end
  endtask

  // One sequence from IDLE; req and dwell are disturbed after the grant edge.
  task automatic run_vec(input vec_t v, input string tag);
    bus.req   = v.req;
    bus.dwell = v.dwell;
    push_seq(v.exp_grant, v.dwell, tag);
    step();
    bus.req   = ~v.req;
    bus.dwell = v.dwell + 8'd3;
    drain(tag);
    bus.req   = 2'b00;
  endtask

  vec_t vecs[9];

  initial begin
    // Tie-break pointer starts at requester 0 and flips to whoever was not served.
    vecs[0] = '{req: 2'b01, dwell: 8'd3,   exp_grant: 2'b01};
    vecs[1] = '{req: 2'b11, dwell: 8'd2,   exp_grant: 2'b10};
    vecs[2] = '{req: 2'b11, dwell: 8'd2,   exp_grant: 2'b01};
    vecs[3] = '{req: 2'b11, dwell: 8'd2,   exp_grant: 2'b10};
    vecs[4] = '{req: 2'b10, dwell: 8'd0,   exp_grant: 2'b10};
    vecs[5] = '{req: 2'b11, dwell: 8'd1,   exp_grant: 2'b01};
    vecs[6] = '{req: 2'b01, dwell: 8'd4,   exp_grant: 2'b01};
    vecs[7] = '{req: 2'b11, dwell: 8'd0,   exp_grant: 2'b10};
    vecs[8] = '{req: 2'b10, dwell: 8'd255, exp_grant: 2'b10};

    rst_n     = 1'b0;
    bus.req   = 2'b11;
    bus.dwell = 8'd5;
`ifdef SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif

    // Reset held for two edges with requests pending.
    push(2'b00, 2'b00, "reset0");
    push(2'b00, 2'b00, "reset1");
    drain("reset");
    rst_n   = 1'b1;
    bus.req = 2'b00;
    push(2'b00, 2'b00, "idle_noreq");
    drain("idle_noreq");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Requests held at 11: alternating owners, one IDLE cycle between sequences.
    bus.req   = 2'b11;
    bus.dwell = 8'd2;
    push_seq(2'b01, 8'd2, "held_a");
    push_seq(2'b10, 8'd2, "held_b");
    push_seq(2'b01, 8'd2, "held_c");
    drain("held");
    bus.req = 2'b00;

    // Reset during the 4th RUN cycle aborts silently and restores the pointer.
    bus.req   = 2'b01;
    bus.dwell = 8'd10;
    for (int i = 0; i < 4; i++) push(2'b01, 2'b01, "midrst_run");
    drain("midrst_run");
    rst_n   = 1'b0;
    bus.req = 2'b11;
    push(2'b00, 2'b00, "midrst_clear");
    drain("midrst_clear");
    rst_n     = 1'b1;
    bus.dwell = 8'd1;
    push_seq(2'b01, 8'd1, "post_rst");
    drain("post_rst");
    bus.req = 2'b00;

`ifdef SEQ_ABORT_EN
    // Serve requester 1 so the pointer favours 0, then abort requester 0's sequence.
    run_vec('{req: 2'b10, dwell: 8'd0, exp_grant: 2'b10}, "pre_abort");
    bus.req   = 2'b01;
    bus.dwell = 8'd5;
    push(2'b01, 2'b01, "abort_run1");
    push(2'b01, 2'b01, "abort_run2");
    drain("abort_run");
    bus.req   = 2'b00;
    bus.abort = 1'b1;
    push(2'b00, 2'b00, "abort_idle");
    drain("abort_idle");
    bus.abort = 1'b0;
    bus.req   = 2'b11;
    bus.dwell = 8'd1;
    push_seq(2'b10, 8'd1, "after_abort");
    drain("after_abort");
    bus.req = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
